sc_apc_sched: RTL

Round-robin scheduler that shares one stochastic-computing APC neuron datapath among NREQ requesters. On each grant it clears the neuron, enables the granted requester's stochastic number generators for one evaluation window, and counts ones on the neuron's `dout` bitstream. It returns the count, tagged with the requester ID, over a valid/ready response channel. It sits between the per-requester SNG/weight banks and the single shared neuron instance.

---
 rtl/sc_apc_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sc_apc_sched.sv
// sc_apc_sched
// Round-robin scheduler sharing one stochastic-computing APC neuron among
// NREQ requesters. A grant clears the neuron, runs the winner's SNGs for a
// fill phase (optional warm-up), then counts ones on neu_dout for cfg_len
// cycles and returns the count tagged with the requester index.
//
// Optional feature macro: SC_APC_SCHED_WARMUP_EN adds a WARM phase of WARMUP
// cycles with sng_en=1 between FILL and RUN. Undefined: FILL goes to RUN.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req        in   [NREQ] request vector, sampled only in IDLE
//   cfg_len    in   [LW] window length, sampled at grant
//   gnt        out  [NREQ] one-hot grant, held until response handshake
//   sng_en     out  enable for the granted requester's SNG/weight streams
//   neu_clr    out  one-cycle clear to neuron state and accumulator
//   neu_dout   in   neuron output bitstream
//   res_valid  out  response valid
//   res_ready  in   response ready
//   res_data   out  [LW] count of ones seen during RUN
//   res_id     out  [$clog2(NREQ)] requester that owns res_data
//   busy       out  high in every state except IDLE
module sc_apc_sched #(
  parameter int NREQ   = 4,
  parameter int LW     = 8,
  parameter int PIPE   = 2,
  parameter int WARMUP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [LW-1:0]           cfg_len,
  output logic [NREQ-1:0]         gnt,
  output logic                    sng_en,
  output logic                    neu_clr,
  input  logic                    neu_dout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [LW-1:0]           res_data,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int PW  = $clog2(PIPE + 1);
  localparam int WW  = $clog2(WARMUP + 1);
  localparam int TW0 = (LW > PW) ? LW : PW;
  // One phase timer serves FILL, WARM and RUN, so it must hold the widest count.
  localparam int TW  = (TW0 > WW) ? TW0 : WW;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FILL,
`ifdef SC_APC_SCHED_WARMUP_EN
    WARM,
`endif
    RUN,
    DONE
  } state_t;

  state_t          state, next;
  logic [TW-1:0]   tmr;
  logic [LW-1:0]   len;
  logic [LW-1:0]   cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   scan_idx;
  logic            found;

  assign res_data = cnt;

  // Round-robin search: first set request bit at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = IW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    sng_en    = 1'b0;
    neu_clr   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (found) next = CLR;
      end
      CLR: begin
        neu_clr = 1'b1;
        next    = (len == '0) ? DONE : FILL;
      end
      FILL: begin
        sng_en = 1'b1;
`ifdef SC_APC_SCHED_WARMUP_EN
        if (tmr == TW'(PIPE - 1)) next = WARM;
`else
        if (tmr == TW'(PIPE - 1)) next = RUN;
`endif
      end
`ifdef SC_APC_SCHED_WARMUP_EN
      WARM: begin
        sng_en = 1'b1;
        if (tmr == TW'(WARMUP - 1)) next = RUN;
      end
`endif
      RUN: begin
        sng_en = 1'b1;
        if (tmr == TW'(len) - TW'(1)) next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Phase timer restarts on every state change and only advances while the
  // streams are enabled, so each phase counts its own cycles from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr    <= '0;
      len    <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      res_id <= '0;
    end else begin
      if (state != next) tmr <= '0;
      else if (sng_en)   tmr <= tmr + TW'(1);

      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << pick;
            res_id <= pick;
            len    <= cfg_len;
          end
        end
        CLR: cnt <= '0;
        RUN: cnt <= cnt + LW'(neu_dout);
        DONE: begin
          if (res_ready) begin
            gnt    <= '0;
            rr_ptr <= (res_id == IW'(NREQ - 1)) ? '0 : res_id + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
